cg_iteration_sequencer: RTL and testbench

Control stage directly upstream of `main_alu`: drives its `reset_mXv1`, `reset_vXv1`, `memoryR_read_address` and `memoryRprev_we` inputs. It consumes the `mXv1_finish`, `vXv1_finish` and `finish_all` status outputs. It runs conjugate-gradient iterations of matrix×vector, vector×vector and residual-save phases until convergence or an iteration cap, and reports progress to the top-level host FSM.

---
 rtl/cg_iteration_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_cg_iteration_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cg_iteration_sequencer.sv
// Purpose : sequences conjugate-gradient iterations (mXv -> vXv -> residual save -> check) for main_alu.
// Latency : 1 cycle from go / finish input to the next state; every output is registered.
// Backpressure: RUN states wait for the ALU finish level; optional watchdog via `CG_TIMEOUT_EN`.
module cg_iteration_sequencer #(
  parameter int number_of_clusters        = 40,
  parameter int memory_read_address_width = 20,
  parameter int max_iterations            = 1000,
  parameter int iter_width                = 16,
  parameter int timeout_cycles            = 65535
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 go,
  input  logic                                 mXv1_finish,
  input  logic                                 vXv1_finish,
  input  logic                                 finish_all,
  output logic                                 reset_mXv1,
  output logic                                 reset_vXv1,
  output logic [memory_read_address_width-1:0] memoryR_read_address,
  output logic                                 memoryRprev_we,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 converged,
  output logic [iter_width-1:0]                iteration_count,
  output logic                                 error
);

  localparam int AW = memory_read_address_width;
  localparam logic [AW-1:0]         ADDR_LAST = AW'(number_of_clusters - 1);
  localparam logic [iter_width-1:0] ITER_CAP  = iter_width'(max_iterations);

  typedef enum logic [2:0] {
    S_IDLE, S_MXV_RST, S_MXV_RUN, S_VXV_RST, S_VXV_RUN, S_SAVE_R, S_CHECK, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [iter_width-1:0] iter_q, iter_d, iter_inc;
  logic                  conv_q, conv_d;
  logic                  rst_m_q, rst_v_q, we_q, busy_q, done_q;

`ifdef CG_TIMEOUT_EN
  // Counter only needs to hold 0..timeout_cycles-1; hitting the last value fires the watchdog.
  localparam int TW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(timeout_cycles - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  // Next-state logic: phase sequencing, residual sweep, iteration bookkeeping.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    iter_d   = iter_q;
    conv_d   = conv_q;
    iter_inc = (iter_q == '1) ? iter_q : iter_q + iter_width'(1);
`ifdef CG_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (go) begin
          iter_d  = '0;
          conv_d  = 1'b0;
`ifdef CG_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_MXV_RST;
        end
      end
      S_MXV_RST: begin
`ifdef CG_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = S_MXV_RUN;
      end
      S_MXV_RUN: begin
        if (mXv1_finish) begin
          state_d = S_VXV_RST;
`ifdef CG_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d   = tmo_q + TW'(1);
`endif
        end
      end
      S_VXV_RST: begin
`ifdef CG_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = S_VXV_RUN;
      end
      S_VXV_RUN: begin
        if (vXv1_finish) begin
          addr_d  = '0;
          state_d = S_SAVE_R;
`ifdef CG_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d   = tmo_q + TW'(1);
`endif
        end
      end
      S_SAVE_R: begin
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          state_d = S_CHECK;
        end else begin
          addr_d  = addr_q + AW'(1);
        end
      end
      S_CHECK: begin
        iter_d = iter_inc;
        if (finish_all) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else if (iter_inc == ITER_CAP) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MXV_RST;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; strobes are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
      rst_m_q <= 1'b1;
      rst_v_q <= 1'b1;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
      rst_m_q <= (state_d != S_MXV_RUN);
      rst_v_q <= (state_d != S_VXV_RUN);
      we_q    <= (state_d == S_SAVE_R);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

`ifdef CG_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign error = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^timeout_cycles;
  assign error              = 1'b0;
`endif

  assign reset_mXv1           = rst_m_q;
  assign reset_vXv1           = rst_v_q;
  assign memoryR_read_address = addr_q;
  assign memoryRprev_we       = we_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign converged            = conv_q;
  assign iteration_count      = iter_q;

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Directed bench for cg_iteration_sequencer (N=4, cap=3, watchdog=20).
// Each task drives one scenario and checks the registered outputs 1ns after the rising edge.
// Output vector order in compact checks: {reset_mXv1, reset_vXv1, we, busy, done, converged, error}.
module tb_cg_iteration_sequencer;
  localparam int N = 4, AW = 20, MAXI = 3, IW = 16, TMO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, go, mXv1_finish, vXv1_finish, finish_all;
  logic          reset_mXv1, reset_vXv1, memoryRprev_we, busy, done, converged, error;
  logic [AW-1:0] memoryR_read_address;
  logic [IW-1:0] iteration_count;

  int checks   = 0;
  int failures = 0;

  // results gathered by the reactive run loop
  int       sweeps, we_cycles, done_cnt;
  logic     d_conv;
  logic [IW-1:0] d_iter;
  bit       finished;

  cg_iteration_sequencer #(
    .number_of_clusters(N), .memory_read_address_width(AW), .max_iterations(MAXI),
    .iter_width(IW), .timeout_cycles(TMO)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .mXv1_finish(mXv1_finish), .vXv1_finish(vXv1_finish),
    .finish_all(finish_all), .reset_mXv1(reset_mXv1), .reset_vXv1(reset_vXv1),
    .memoryR_read_address(memoryR_read_address), .memoryRprev_we(memoryRprev_we),
    .busy(busy), .done(done), .converged(converged), .iteration_count(iteration_count),
    .error(error)
  );

  function automatic logic [6:0] outs();
    return {reset_mXv1, reset_vXv1, memoryRprev_we, busy, done, converged, error};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instant-response ALU: finish asserted as soon as a unit is out of reset; runs until idle.
  task automatic run_to_idle(input int budget);
    logic prev_we;
    prev_we = 1'b0; sweeps = 0; we_cycles = 0; done_cnt = 0; finished = 0;
    d_iter = '0; d_conv = 1'b0;
    for (int c = 0; c < budget && !finished; c++) begin
      mXv1_finish = busy && !reset_mXv1;
      vXv1_finish = busy && !reset_vXv1;
      tick();
      if (memoryRprev_we) begin
        we_cycles++;
        if (!prev_we) sweeps++;
      end
      prev_we = memoryRprev_we;
      if (done) begin
        done_cnt++;
        d_iter = iteration_count;
        d_conv = converged;
      end
      if (!busy) finished = 1;
    end
    mXv1_finish = 1'b0;
    vXv1_finish = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; go = 1'b0; mXv1_finish = 1'b0; vXv1_finish = 1'b0; finish_all = 1'b0;
    tick(); tick();
    checks++;
    if (outs() !== 7'b1100000) begin
      failures++; $display("FAIL reset_outs got=%b exp=1100000", outs());
    end
    checks++;
    if (memoryR_read_address !== '0 || iteration_count !== '0) begin
      failures++; $display("FAIL reset_addr_iter got=%0d/%0d exp=0/0", memoryR_read_address, iteration_count);
    end
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (outs() !== 7'b1100000) begin
      failures++; $display("FAIL idle_no_go got=%b exp=1100000", outs());
    end
  endtask

  task automatic test_converge();
    finish_all = 1'b1;
    go = 1'b1; tick(); go = 1'b0;
    checks++;
    if (outs() !== 7'b1101000) begin
      failures++; $display("FAIL cv_mxv_rst got=%b exp=1101000", outs());
    end
    tick();
    checks++;
    if (outs() !== 7'b0101000) begin
      failures++; $display("FAIL cv_mxv_run got=%b exp=0101000", outs());
    end
    repeat (10) tick();
    checks++;
    if (outs() !== 7'b0101000) begin
      failures++; $display("FAIL cv_mxv_wait got=%b exp=0101000", outs());
    end
    mXv1_finish = 1'b1; tick(); mXv1_finish = 1'b0;
    checks++;
    if (outs() !== 7'b1101000) begin
      failures++; $display("FAIL cv_vxv_rst got=%b exp=1101000", outs());
    end
    tick();
    checks++;
    if (outs() !== 7'b1001000) begin
      failures++; $display("FAIL cv_vxv_run got=%b exp=1001000", outs());
    end
    repeat (5) tick();
    vXv1_finish = 1'b1; tick(); vXv1_finish = 1'b0;
    checks++;
    if (outs() !== 7'b1111000 || memoryR_read_address !== 20'd0) begin
      failures++; $display("FAIL cv_save0 got=%b/%0d exp=1111000/0", outs(), memoryR_read_address);
    end
    for (int a = 1; a < N; a++) begin
      tick();
      checks++;
      if (memoryRprev_we !== 1'b1 || memoryR_read_address !== AW'(a)) begin
        failures++; $display("FAIL cv_save_addr got=%b/%0d exp=1/%0d", memoryRprev_we, memoryR_read_address, a);
      end
    end
    tick();
    checks++;
    if (outs() !== 7'b1101000 || memoryR_read_address !== 20'd0) begin
      failures++; $display("FAIL cv_check got=%b/%0d exp=1101000/0", outs(), memoryR_read_address);
    end
    tick();
    checks++;
    if (outs() !== 7'b1101110 || iteration_count !== 16'd1) begin
      failures++; $display("FAIL cv_done got=%b/%0d exp=1101110/1", outs(), iteration_count);
    end
    tick();
    checks++;
    if (outs() !== 7'b1100010 || iteration_count !== 16'd1) begin
      failures++; $display("FAIL cv_idle got=%b/%0d exp=1100010/1", outs(), iteration_count);
    end
  endtask

  task automatic test_iteration_cap();
    finish_all = 1'b0;
    go = 1'b1; tick(); go = 1'b0;
    checks++;
    if (converged !== 1'b0 || iteration_count !== 16'd0) begin
      failures++; $display("FAIL cap_clear got=%b/%0d exp=0/0", converged, iteration_count);
    end
    run_to_idle(300);
    checks++;
    if (!finished) begin
      failures++; $display("FAIL cap_timeout got=busy exp=idle");
    end
    checks++;
    if (sweeps !== 3 || we_cycles !== 12) begin
      failures++; $display("FAIL cap_sweeps got=%0d/%0d exp=3/12", sweeps, we_cycles);
    end
    checks++;
    if (done_cnt !== 1 || d_iter !== 16'd3 || d_conv !== 1'b0) begin
      failures++; $display("FAIL cap_done got=%0d/%0d/%b exp=1/3/0", done_cnt, d_iter, d_conv);
    end
  endtask

  task automatic test_spurious_finish();
    finish_all = 1'b1;
    go = 1'b1; tick(); go = 1'b0;
    mXv1_finish = 1'b1; tick();
    mXv1_finish = 1'b0; vXv1_finish = 1'b1;
    checks++;
    if (outs() !== 7'b0101000) begin
      failures++; $display("FAIL sp_mxv_rst_ignored got=%b exp=0101000", outs());
    end
    tick(); tick();
    checks++;
    if (outs() !== 7'b0101000) begin
      failures++; $display("FAIL sp_vxv_in_mxv got=%b exp=0101000", outs());
    end
    vXv1_finish = 1'b0; mXv1_finish = 1'b1; tick(); mXv1_finish = 1'b0;
    tick();
    mXv1_finish = 1'b1; tick(); tick(); mXv1_finish = 1'b0;
    checks++;
    if (outs() !== 7'b1001000) begin
      failures++; $display("FAIL sp_mxv_in_vxv got=%b exp=1001000", outs());
    end
    run_to_idle(100);
    checks++;
    if (!finished || done_cnt !== 1 || d_iter !== 16'd1 || d_conv !== 1'b1) begin
      failures++; $display("FAIL sp_done got=%0d/%0d/%b exp=1/1/1", done_cnt, d_iter, d_conv);
    end
  endtask

  task automatic test_go_while_busy();
    finish_all = 1'b1;
    go = 1'b1; tick(); tick(); tick(); tick(); go = 1'b0;
    checks++;
    if (outs() !== 7'b0101000 || iteration_count !== 16'd0) begin
      failures++; $display("FAIL gb_ignored got=%b/%0d exp=0101000/0", outs(), iteration_count);
    end
    run_to_idle(100);
    checks++;
    if (!finished || done_cnt !== 1 || d_iter !== 16'd1) begin
      failures++; $display("FAIL gb_done got=%0d/%0d exp=1/1", done_cnt, d_iter);
    end
  endtask

  task automatic test_reset_mid_save();
    int  hits;
    bit  found;
    finish_all = 1'b0; found = 0;
    go = 1'b1; tick(); go = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      mXv1_finish = busy && !reset_mXv1;
      vXv1_finish = busy && !reset_vXv1;
      tick();
      if (iteration_count == 16'd1 && memoryRprev_we && memoryR_read_address == 20'd2) found = 1;
    end
    mXv1_finish = 1'b0; vXv1_finish = 1'b0;
    checks++;
    if (!found) begin
      failures++; $display("FAIL rs_reach_addr2 got=not_reached exp=reached");
    end
    reset = 1'b0; #1;
    checks++;
    if (outs() !== 7'b1100000 || memoryR_read_address !== '0 || iteration_count !== '0) begin
      failures++; $display("FAIL rs_immediate got=%b/%0d/%0d exp=1100000/0/0", outs(), memoryR_read_address, iteration_count);
    end
    hits = 0;
    repeat (3) begin
      tick();
      if (done) hits++;
    end
    reset = 1'b1;
    tick();
    checks++;
    if (hits !== 0 || done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rs_no_done got=%0d/%b exp=0/0", hits, busy);
    end
    finish_all = 1'b1;
    go = 1'b1; tick(); go = 1'b0;
    checks++;
    if (busy !== 1'b1 || iteration_count !== 16'd0) begin
      failures++; $display("FAIL rs_restart got=%b/%0d exp=1/0", busy, iteration_count);
    end
    run_to_idle(100);
    checks++;
    if (!finished || done_cnt !== 1 || d_iter !== 16'd1) begin
      failures++; $display("FAIL rs_rerun got=%0d/%0d exp=1/1", done_cnt, d_iter);
    end
  endtask

`ifdef CG_TIMEOUT_EN
  task automatic test_timeout();
    int dk;
    finish_all = 1'b0; dk = -1;
    go = 1'b1; tick(); go = 1'b0;
    tick();
    for (int k = 1; k <= 60 && dk < 0; k++) begin
      tick();
      if (done) dk = k;
    end
    checks++;
    if (dk !== TMO || error !== 1'b1) begin
      failures++; $display("FAIL to_done got=%0d/%b exp=%0d/1", dk, error, TMO);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || error !== 1'b1) begin
      failures++; $display("FAIL to_sticky got=%b/%b exp=0/1", busy, error);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_converge();
    test_iteration_cap();
    test_spurious_finish();
    test_go_while_busy();
    test_reset_mid_save();
`ifdef CG_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
